// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Decodes the IR opcode and sequences the datapath strobes through fetch,
// decode, execute, memory and writeback, stretching memory cycles on
// mem_ready and counting retired instructions.
//
// state      | meaning
// -----------+------------------------------------------------------------
// FETCH  (0) | read instruction, PC <= PC+4 and IR load when mem_ready
// DECODE (1) | read registers, precompute branch target, dispatch on opcode
// MEMADR (2) | compute load/store effective address
// MEMRD  (3) | load data read, held until mem_ready
// MEMWB  (4) | write loaded data to rt
// MEMWR  (5) | store data write, held until mem_ready
// EXEC   (6) | R-type ALU operation selected by funct
// RCOMP  (7) | write ALU result to rd
// BRANCH (8) | beq compare, conditional PC update to target
// JUMP   (9) | unconditional PC update to jump target
// 10..15     | unused, all outputs 0, return to FETCH
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t state_r;
    state_t state_nxt;
    logic   retire;

    // Write-type strobes before the reset mask is applied.
    logic pc_write_c;
    logic pc_write_cond_c;
    logic mem_write_c;
    logic reg_write_c;
    logic ir_write_c;
    logic illegal_op_c;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_FETCH;
        else        state_r <= state_nxt;
    end

    // Next-state and Moore output decode; FETCH/DECODE also look at inputs.
    always_comb begin
        state_nxt       = S_FETCH;
        retire          = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        mem_write_c     = 1'b0;
        reg_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        illegal_op_c    = 1'b0;
        iord            = 1'b0;
        mem_read        = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        reg_dst         = 1'b0;
        pc_source       = 2'b00;
        alu_src_b       = 2'b00;
        aluop           = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                pc_write_c = mem_ready;
                ir_write_c = mem_ready;
                state_nxt  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_R:         state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        illegal_op_c = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Opcode is a load or store here; anything else just refetches.
                if (opcode == OP_LW)      state_nxt = S_MEMRD;
                else if (opcode == OP_SW) state_nxt = S_MEMWR;
                else                      state_nxt = S_FETCH;
            end
            S_MEMRD: begin
                mem_read  = 1'b1;
                iord      = 1'b1;
                state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                retire      = 1'b1;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord        = 1'b1;
                state_nxt   = mem_ready ? S_FETCH : S_MEMWR;
                retire      = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                state_nxt = S_RCOMP;
            end
            S_RCOMP: begin
                reg_dst     = 1'b1;
                reg_write_c = 1'b1;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                aluop           = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source       = 2'b01;
                retire          = 1'b1;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_source  = 2'b10;
                retire     = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Retired-instruction counter, bumped on the edge that re-enters FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    // Write strobes are held off while reset is asserted.
    assign pc_write      = pc_write_c & rst_n;
    assign pc_write_cond = pc_write_cond_c & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign ir_write      = ir_write_c & rst_n;
    assign illegal_op    = illegal_op_c & rst_n;
    assign state         = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each driven cycle pushes the
// expected state, strobes and retired count; the low clock phase pops and
// compares. A second instance with CNT_W=2 exercises counter wrap.
module tb_multicycle_control;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, RCOMP = 4'd7,
                           BRANCH = 4'd8, JUMP = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg;
    logic        ir_write, alu_src_a, reg_write, reg_dst, illegal_op;
    logic [1:0]  pc_source, alu_src_b, aluop;
    logic [3:0]  state;
    logic [15:0] retired;

    logic        pc_write2, pc_write_cond2, iord2, mem_read2, mem_write2, mem_to_reg2;
    logic        ir_write2, alu_src_a2, reg_write2, reg_dst2, illegal_op2;
    logic [1:0]  pc_source2, alu_src_b2, aluop2;
    logic [3:0]  state2;
    logic [1:0]  retired2;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] outs;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_ret;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .reg_write(reg_write),
        .reg_dst(reg_dst), .pc_source(pc_source), .alu_src_b(alu_src_b),
        .aluop(aluop), .state(state), .illegal_op(illegal_op), .retired(retired)
    );

    multicycle_control #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .iord(iord2),
        .mem_read(mem_read2), .mem_write(mem_write2), .mem_to_reg(mem_to_reg2),
        .ir_write(ir_write2), .alu_src_a(alu_src_a2), .reg_write(reg_write2),
        .reg_dst(reg_dst2), .pc_source(pc_source2), .alu_src_b(alu_src_b2),
        .aluop(aluop2), .state(state2), .illegal_op(illegal_op2), .retired(retired2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Strobe table written from the state descriptions; packed as
    // {pcw,pcwc,iord,mrd,mwr,m2r,irw,asa,rw,rd,pcsrc,asb,aluop,ill}.
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic mr,
                                             input logic [5:0] op);
        logic pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd, ill;
        logic [1:0] ps, asb, aop;
        {pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd, ill} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            FETCH:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
            DECODE: begin
                asb = 2'b11;
                ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J});
            end
            MEMADR: begin asa = 1; asb = 2'b10; end
            MEMRD:  begin mrd = 1; io = 1; end
            MEMWB:  begin rw = 1; m2r = 1; end
            MEMWR:  begin mwr = 1; io = 1; end
            EXEC:   begin asa = 1; aop = 2'b10; end
            RCOMP:  begin rd = 1; rw = 1; end
            BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; ps = 2'b01; end
            JUMP:   begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, m2r, irw, asa, rw, rd, ps, asb, aop, ill};
    endfunction

    task automatic compare_one();
        exp_t e;
        logic [16:0] obs;
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg, ir_write,
               alu_src_a, reg_write, reg_dst, pc_source, alu_src_b, aluop, illegal_op};
        check_eq("state", 32'(state), 32'(e.st));
        check_eq("outs", 32'(obs), 32'(e.outs));
        check_eq("retired", 32'(retired), 32'(e.ret));
        check_eq("retired_w2", 32'(retired2), 32'(e.ret[1:0]));
        check_eq("state_w2", 32'(state2), 32'(e.st));
    endtask

    // One clock cycle in which the DUT should sit in state st.
    task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op;
        mem_ready = mr;
        e.st = st; e.outs = exp_outs(st, mr, op); e.ret = exp_ret;
        sb.push_back(e);
        @(negedge clk);
        compare_one();
    endtask

    // Asynchronous reset from the current time: immediate abort check, one
    // full reset cycle with mem_ready=1, release in the low phase.
    task automatic do_reset();
        exp_t e;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'($urandom_range(0, 63));
        exp_ret = '0;
        #1;
        e.st = FETCH; e.outs = exp_outs(FETCH, 1'b0, opcode); e.ret = exp_ret;
        sb.push_back(e);
        compare_one();
        @(posedge clk);
        #1;
        sb.push_back(e);
        @(negedge clk);
        compare_one();
        #1 rst_n = 1'b1;
    endtask

    // Full instruction; after_reset means the first fetch edge already follows
    // the reset release with mem_ready=1.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit after_reset);
        if (!after_reset) begin
            repeat (fw) step(6'($urandom_range(0, 63)), 1'b0, FETCH);
            step(6'($urandom_range(0, 63)), 1'b1, FETCH);
        end
        step(op, 1'b1, DECODE);
        case (op)
            OP_R: begin
                step(6'($urandom_range(0, 63)), 1'b1, EXEC);
                step(6'($urandom_range(0, 63)), 1'b1, RCOMP);
            end
            OP_LW: begin
                step(op, 1'b1, MEMADR);
                repeat (mw) step(6'($urandom_range(0, 63)), 1'b0, MEMRD);
                step(6'($urandom_range(0, 63)), 1'b1, MEMRD);
                step(6'($urandom_range(0, 63)), 1'b1, MEMWB);
            end
            OP_SW: begin
                step(op, 1'b1, MEMADR);
                repeat (mw) step(6'($urandom_range(0, 63)), 1'b0, MEMWR);
                step(6'($urandom_range(0, 63)), 1'b1, MEMWR);
            end
            OP_BEQ: step(6'($urandom_range(0, 63)), 1'b1, BRANCH);
            OP_J:   step(6'($urandom_range(0, 63)), 1'b1, JUMP);
            default: ;
        endcase
        if (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J}) exp_ret = exp_ret + 16'd1;
    endtask

    initial begin
        logic [5:0] ops [6];
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
        ops[3] = OP_BEQ; ops[4] = OP_J; ops[5] = OP_BAD;
        opcode = OP_R;
        exp_ret = '0;
        #2;
        do_reset();
        run_instr(OP_R, 0, 0, 1'b1);
        run_instr(OP_LW, 0, 2, 1'b0);
        run_instr(OP_SW, 0, 2, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_BAD, 0, 0, 1'b0);
        run_instr(OP_R, 3, 0, 1'b0);
        run_instr(6'b001000, 1, 0, 1'b0);

        // Abort a load while it waits in MEMRD.
        step(6'd5, 1'b1, FETCH);
        step(OP_LW, 1'b1, DECODE);
        step(OP_LW, 1'b1, MEMADR);
        step(6'd7, 1'b0, MEMRD);
        #2;
        do_reset();
        run_instr(OP_BEQ, 0, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), 1'b0);
        end

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
